uart_mp_frame_ctrl: RTL
=======================

Name: uart_mp_frame_ctrl

Overview:
Command-framed UART front-end controller for the multi-precision arithmetic core. It sits between the byte-level uart_rx/uart_tx instances and a carry-chained adder core.
- Parses a frame: command byte, then operand A, then operand B, all MSB-first.
- Supports add and subtract.
- Returns a carry byte plus the result, or a one-byte error code.
- Generalises the fixed add-only flow with command decode, a subtract mode, inter-byte timeout and error reporting.

Parameters:
OPERAND_WIDTH, 512, operand width in bits; must be a multiple of 8, at least 16.
NBYTES, OPERAND_WIDTH/8, bytes per operand (derived, not overridden).
CLK_FREQ, 125_000_000, clock frequency in Hz.
TIMEOUT_CYCLES, CLK_FREQ/100, maximum idle cycles between bytes inside a frame (10 ms).

Ports:
iClk  in  1  clock; all logic on rising edge.
iRstN  in  1  synchronous reset, active-low.
iRxByte  in  8  received byte from uart_rx.
iRxValid  in  1  one-cycle strobe, iRxByte valid.
oTxByte  out  8  byte to uart_tx.
oTxStart  out  1  one-cycle strobe, launches oTxByte.
iTxBusy  in  1  uart_tx busy.
iTxDone  in  1  one-cycle strobe, byte fully transmitted.
oCoreStart  out  1  one-cycle start strobe to the adder core.
oCoreOpA  out  OPERAND_WIDTH  operand A, held stable from start to done.
oCoreOpB  out  OPERAND_WIDTH  operand B as presented to the core (B, or ~B for subtract).
oCoreCin  out  1  core carry-in (1 for subtract).
iCoreRes  in  OPERAND_WIDTH+1  core result {carry, sum}.
iCoreDone  in  1  one-cycle strobe, iCoreRes valid.
oBusy  out  1  high whenever the state is not IDLE.
oFrameErr  out  1  one-cycle strobe on bad command or timeout.

Behaviour:
- Reset (iRstN=0 at a clock edge): state IDLE. All outputs 0, all internal registers 0. Reset mid-frame, mid-core or mid-TX aborts immediately; no further oTxStart is issued.
- IDLE:
  - iRxValid with 0x2B ('+'): mode=ADD, go to RX_A.
  - iRxValid with 0x2D ('-'): mode=SUB, go to RX_A.
  - Any other byte: load error code 0xEE, pulse oFrameErr, go to ERR_TX.
- RX_A, RX_B:
  - Each iRxValid shifts the byte into the LSB of the operand register and increments the byte counter.
  - After NBYTES bytes, RX_A moves to RX_B, and RX_B moves to CORE_START.
- Timeout:
  - A counter clears on entry to RX_A/RX_B and on every iRxValid, and increments otherwise.
  - Reaching TIMEOUT_CYCLES discards the partial frame, loads error code 0xE7, pulses oFrameErr and goes to ERR_TX.
  - iRxValid on the same cycle as expiry: the byte wins and the counter clears.
- CORE_START:
  - oCoreOpB = B (ADD) or ~B (SUB); oCoreCin = mode==SUB.
  - oCoreStart high for exactly one cycle, then CORE_WAIT.
- CORE_WAIT: on iCoreDone, latch {7'b0, iCoreRes[OPERAND_WIDTH]} followed by iCoreRes[OPERAND_WIDTH-1:0] into an (NBYTES+1)-byte TX buffer, then go to TX.
- Result meaning:
  - ADD: carry byte = overflow flag.
  - SUB: A+~B+1, so carry byte 1 means A>=B (no borrow) and 0 means borrow.
- TX:
  - When iTxBusy=0: drive the buffer MSB byte on oTxByte, pulse oTxStart for one cycle, shift the buffer left by 8, go to TX_WAIT.
  - After NBYTES+1 bytes have been sent, go to IDLE.
- TX_WAIT: on iTxDone go to TX.
- ERR_TX: send the single error byte with the same TX/TX_WAIT handshake, then go to IDLE.
- iRxValid outside IDLE/RX_A/RX_B (CORE_*, TX*, ERR_TX) is dropped silently and does not start a new frame.
- oCoreOpA/oCoreOpB/oCoreCin hold their values until the next frame's CORE_START.
- Latency: oCoreStart asserts 1 cycle after the last B byte's iRxValid. The first oTxStart asserts at most 2 cycles after iCoreDone when iTxBusy=0.

Test Plan:
(All scenarios use OPERAND_WIDTH=16, NBYTES=2, TIMEOUT_CYCLES=1000, a behavioural adder core and a behavioural TX model.)
1. Add: 0x2B 0x12 0x34 0x00 0x01 -> oCoreOpA=0x1234, oCoreOpB=0x0001, oCoreCin=0; TX 0x00 0x12 0x35.
2. Add overflow: 0x2B 0xFF 0xFF 0x00 0x01 -> TX 0x01 0x00 0x00.
3. Subtract: 0x2D 0x00 0x05 0x00 0x03 -> oCoreOpB=0xFFFC, oCoreCin=1; TX 0x01 0x00 0x02.
4. Subtract with borrow: 0x2D 0x00 0x03 0x00 0x05 -> TX 0x00 0xFF 0xFE.
5. Bad command then timeout:
   - 0x41 -> oFrameErr pulse, TX 0xEE, back in IDLE.
   - 0x2B 0x12 then 1000 idle cycles -> oFrameErr pulse, TX 0xE7.
   - Next valid frame completes correctly.
6. Reset mid-TX: assert iRstN=0 for 1 cycle after the first result byte -> no further oTxStart, all outputs 0, oBusy=0; the following frame completes correctly.

Source files
------------

// File: rtl/uart_mp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mp_frame_ctrl
//
// Command-framed UART front end for the multi-precision adder core. A frame is
// a command byte ('+' or '-'), then operand A, then operand B, both MSB-first.
// The controller launches the adder core and returns a carry byte followed by
// the result (MSB-first), or a single error byte for a bad command (0xEE) or
// an inter-byte timeout (0xE7).
//
// Ports:
//   iClk        clock, all logic on rising edge
//   iRstN       synchronous reset, active-low
//   iRxByte     received byte from uart_rx
//   iRxValid    one-cycle strobe, iRxByte valid
//   oTxByte     byte to uart_tx
//   oTxStart    one-cycle strobe launching oTxByte
//   iTxBusy     uart_tx busy
//   iTxDone     one-cycle strobe, byte fully transmitted
//   oCoreStart  one-cycle start strobe to the adder core
//   oCoreOpA    operand A to the core
//   oCoreOpB    operand B as presented to the core (B or ~B)
//   oCoreCin    core carry-in (1 for subtract)
//   iCoreRes    core result {carry, sum}
//   iCoreDone   one-cycle strobe, iCoreRes valid
//   oBusy       high whenever the controller is not idle
//   oFrameErr   one-cycle strobe on bad command or timeout
// ---------------------------------------------------------------------------
module uart_mp_frame_ctrl #(
  parameter int OPERAND_WIDTH  = 512,
  parameter int CLK_FREQ       = 125_000_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic [7:0]               iRxByte,
  input  logic                     iRxValid,
  output logic [7:0]               oTxByte,
  output logic                     oTxStart,
  input  logic                     iTxBusy,
  input  logic                     iTxDone,
  output logic                     oCoreStart,
  output logic [OPERAND_WIDTH-1:0] oCoreOpA,
  output logic [OPERAND_WIDTH-1:0] oCoreOpB,
  output logic                     oCoreCin,
  input  logic [OPERAND_WIDTH:0]   iCoreRes,
  input  logic                     iCoreDone,
  output logic                     oBusy,
  output logic                     oFrameErr
);

  localparam int NBYTES = OPERAND_WIDTH / 8;
  localparam int TXW    = 8 * (NBYTES + 1);
  localparam int CNT_W  = $clog2(NBYTES + 2);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] RES_BYTES = CNT_W'(NBYTES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_ADD     = 8'h2B;
  localparam logic [7:0] CMD_SUB     = 8'h2D;
  localparam logic [7:0] ERR_BAD_CMD = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE7;

  typedef enum logic [2:0] {
    IDLE,
    RX_A,
    RX_B,
    CORE_START,
    CORE_WAIT,
    TX,
    TX_WAIT,
    ERR_TX
  } state_e;

  state_e                   state_q, state_d;
  logic                     modeSub_q, modeSub_d;
  logic [CNT_W-1:0]         byteCnt_q, byteCnt_d;
  logic [TMO_W-1:0]         tmoCnt_q, tmoCnt_d;
  logic [OPERAND_WIDTH-1:0] opA_q, opA_d;
  logic [OPERAND_WIDTH-1:0] opB_q, opB_d;
  logic [OPERAND_WIDTH-1:0] coreOpA_q, coreOpA_d;
  logic [OPERAND_WIDTH-1:0] coreOpB_q, coreOpB_d;
  logic                     coreCin_q, coreCin_d;
  logic [TXW-1:0]           txBuf_q, txBuf_d;
  logic [CNT_W-1:0]         txLeft_q, txLeft_d;
  logic [7:0]               txByte_q, txByte_d;
  logic                     txStart_q, txStart_d;
  logic                     frameErr_q, frameErr_d;

  // Operand B including the byte arriving this cycle; the core operand is
  // captured from this on the final B byte so it is ready in CORE_START.
  logic [OPERAND_WIDTH-1:0] opBNext;
  assign opBNext = {opB_q[OPERAND_WIDTH-9:0], iRxByte};

  assign oTxByte    = txByte_q;
  assign oTxStart   = txStart_q;
  assign oCoreStart = (state_q == CORE_START);
  assign oCoreOpA   = coreOpA_q;
  assign oCoreOpB   = coreOpB_q;
  assign oCoreCin   = coreCin_q;
  assign oBusy      = (state_q != IDLE);
  assign oFrameErr  = frameErr_q;

  // Register every piece of state; reset clears all of it so an abort in any
  // phase leaves no pending transmit or stale operands behind.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      modeSub_q  <= 1'b0;
      byteCnt_q  <= '0;
      tmoCnt_q   <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      coreOpA_q  <= '0;
      coreOpB_q  <= '0;
      coreCin_q  <= 1'b0;
      txBuf_q    <= '0;
      txLeft_q   <= '0;
      txByte_q   <= '0;
      txStart_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      modeSub_q  <= modeSub_d;
      byteCnt_q  <= byteCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      coreOpA_q  <= coreOpA_d;
      coreOpB_q  <= coreOpB_d;
      coreCin_q  <= coreCin_d;
      txBuf_q    <= txBuf_d;
      txLeft_q   <= txLeft_d;
      txByte_q   <= txByte_d;
      txStart_q  <= txStart_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state and datapath logic. Strobes default low; everything else holds.
  // ERR_TX shares the transmit path: the error code sits in the buffer MSB
  // byte with a remaining count of one.
  always_comb begin
    state_d    = state_q;
    modeSub_d  = modeSub_q;
    byteCnt_d  = byteCnt_q;
    tmoCnt_d   = tmoCnt_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    coreOpA_d  = coreOpA_q;
    coreOpB_d  = coreOpB_q;
    coreCin_d  = coreCin_q;
    txBuf_d    = txBuf_q;
    txLeft_d   = txLeft_q;
    txByte_d   = txByte_q;
    txStart_d  = 1'b0;
    frameErr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (iRxValid) begin
          if (iRxByte == CMD_ADD || iRxByte == CMD_SUB) begin
            modeSub_d = (iRxByte == CMD_SUB);
            byteCnt_d = '0;
            tmoCnt_d  = '0;
            state_d   = RX_A;
          end else begin
            txBuf_d    = {ERR_BAD_CMD, {(TXW-8){1'b0}}};
            txLeft_d   = CNT_W'(1);
            frameErr_d = 1'b1;
            state_d    = ERR_TX;
          end
        end
      end

      RX_A, RX_B: begin
        // A byte arriving on the expiry cycle still counts.
        if (iRxValid) begin
          tmoCnt_d  = '0;
          byteCnt_d = byteCnt_q + CNT_W'(1);
          if (state_q == RX_A) begin
            opA_d = {opA_q[OPERAND_WIDTH-9:0], iRxByte};
          end else begin
            opB_d = opBNext;
          end
          if (byteCnt_q == LAST_BYTE) begin
            byteCnt_d = '0;
            if (state_q == RX_A) begin
              state_d = RX_B;
            end else begin
              coreOpA_d = opA_q;
              coreOpB_d = modeSub_q ? ~opBNext : opBNext;
              coreCin_d = modeSub_q;
              state_d   = CORE_START;
            end
          end
        end else if (tmoCnt_q == TMO_LAST) begin
          opA_d      = '0;
          opB_d      = '0;
          byteCnt_d  = '0;
          tmoCnt_d   = '0;
          txBuf_d    = {ERR_TIMEOUT, {(TXW-8){1'b0}}};
          txLeft_d   = CNT_W'(1);
          frameErr_d = 1'b1;
          state_d    = ERR_TX;
        end else begin
          tmoCnt_d = tmoCnt_q + TMO_W'(1);
        end
      end

      CORE_START: begin
        state_d = CORE_WAIT;
      end

      CORE_WAIT: begin
        if (iCoreDone) begin
          txBuf_d  = {7'b0, iCoreRes};
          txLeft_d = RES_BYTES;
          state_d  = TX;
        end
      end

      TX, ERR_TX: begin
        if (!iTxBusy) begin
          txByte_d  = txBuf_q[TXW-1 -: 8];
          txStart_d = 1'b1;
          txBuf_d   = txBuf_q << 8;
          txLeft_d  = txLeft_q - CNT_W'(1);
          state_d   = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (iTxDone) begin
          state_d = (txLeft_q == '0) ? IDLE : TX;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
